// File: rtl/sar_conv_sequencer_pkg.sv
// Shared types for the SAR conversion sequencer: FSM states, result entry, channel search.
package sar_pkg;

  localparam int BIT_ADC  = 6;
  localparam int RES_CH_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    NEXT
  } state_t;

  typedef struct packed {
    logic [RES_CH_W-1:0] ch;
    logic [BIT_ADC-1:0]  code;
  } res_t;

  // Index of the lowest set bit of mask at or above 'from'; -1 when none.
  function automatic int lowest_set_from(input logic [31:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i >= from)) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sar_conv_sequencer_fifo.sv
// Result FIFO with registered head/valid/full; push and pop in one cycle both succeed even when full.
// A push into a full FIFO without a pop is dropped and flagged on 'drop' for that cycle.
module sar_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign do_pop     = pop && valid;
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
      valid <= (count_next != '0);
      full  <= (count_next == (AW+1)'(DEPTH));
      // New entry becomes the head only when it lands in an empty (or emptying) FIFO.
      if (do_push && ((count == '0) || (do_pop && (count == (AW+1)'(1)))))
        head <= wr_data;
      else if (do_pop)
        head <= mem[rd_ptr_inc];
    end
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Sequences the SAR ADC over a channel mask: settle in reset, convert with watchdog, queue {ch, code}.
// All outputs registered; results wait in the FIFO until RES_READY, overflow drops the new result.
module sar_conv_sequencer #(
  parameter int BIT_ADC     = sar_pkg::BIT_ADC,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    CONT,
  input  logic [N_CH-1:0]         CH_MASK,
  input  logic                    CLR_ERR,
  input  logic                    SAR_EOC,
  input  logic [BIT_ADC-1:0]      SAR_DOUT,
  output logic                    SAR_XRST,
  output logic [CH_W-1:0]         CH_SEL,
  output logic                    BUSY,
  output logic                    RES_VALID,
  input  logic                    RES_READY,
  output logic [CH_W+BIT_ADC-1:0] RES_DATA,
  output logic                    OVF,
  output logic                    TIMEOUT_ERR
);

  import sar_pkg::*;

  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  logic [N_CH-1:0] act_mask;
  logic [ST_W-1:0] settle_cnt;
  logic [WD_W-1:0] wd_cnt;
  int              next_idx;
  int              wrap_idx;
  logic            wd_hit;
  logic            push;
  logic            drop;
  res_t            push_res;
  res_t            head;

  always_comb begin
    next_idx = lowest_set_from(32'(act_mask), int'(CH_SEL) + 1);
    wrap_idx = lowest_set_from(32'(CH_MASK), 0);
  end

  // EOC takes priority over a watchdog expiry landing on the same cycle.
  assign wd_hit        = (state == CONVERT) && !SAR_EOC && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign push          = (state == CONVERT) && SAR_EOC;
  assign push_res.ch   = CH_SEL;
  assign push_res.code = SAR_DOUT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      SAR_XRST   <= 1'b0;
      CH_SEL     <= '0;
      BUSY       <= 1'b0;
      act_mask   <= '0;
      settle_cnt <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((START || CONT) && (CH_MASK != '0)) begin
            act_mask   <= CH_MASK;
            CH_SEL     <= CH_W'(wrap_idx);
            settle_cnt <= '0;
            BUSY       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == ST_W'(SETTLE_CYC)) begin
            SAR_XRST <= 1'b1;
            wd_cnt   <= '0;
            state    <= CONVERT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CONVERT: begin
          if (SAR_EOC || wd_hit) begin
            SAR_XRST <= 1'b0;
            state    <= NEXT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (next_idx >= 0) begin
            CH_SEL     <= CH_W'(next_idx);
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (CONT && (CH_MASK != '0)) begin
            act_mask   <= CH_MASK;
            CH_SEL     <= CH_W'(wrap_idx);
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          SAR_XRST <= 1'b0;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF         <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (drop)         OVF <= 1'b1;
      else if (CLR_ERR) OVF <= 1'b0;
      if (wd_hit)       TIMEOUT_ERR <= 1'b1;
      else if (CLR_ERR) TIMEOUT_ERR <= 1'b0;
    end
  end

  sar_result_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .wr_data (push_res),
    .pop     (RES_READY),
    .head    (head),
    .valid   (RES_VALID),
    .drop    (drop)
  );

  assign RES_DATA = head;

endmodule
